// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared definitions for the iterative IEEE-754 divider.
//   - FSM state encodings (plain localparam constants)
//   - bit positions inside the 5-bit exception flag vector
//   - helpers deriving quotient length, exponent bias and the canonical qNaN
package fp_div_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_DIV    = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // flags = {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Quotient bits developed: hidden + fraction + normalise + guard.
  function automatic int q_bits_of(input int man_w);
    return man_w + 3;
  endfunction

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  // Returned zero-extended to 64 bits; callers cast down to their width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_div_unpack.sv
// fp_div_unpack: combinational classification of one dividend/divisor pair.
// Ports:
//   a, b        operands (sign | exponent | fraction)
//   special     result is fully determined without dividing
//   spec_q      that result (qNaN, signed inf or signed zero)
//   spec_flags  flags that go with spec_q
//   sign        result sign, sa ^ sb
//   man_a/man_b significands with the hidden one restored
//   exp_q       biased result exponent before normalisation (signed)
// Exponent 0 is treated as zero: subnormal inputs flush silently.
module fp_div_unpack
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   special,
  output logic [EXP_W+MAN_W:0]   spec_q,
  output logic [4:0]             spec_flags,
  output logic                   sign,
  output logic [MAN_W:0]         man_a,
  output logic [MAN_W:0]         man_b,
  output logic signed [EXP_W+1:0] exp_q
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(bias_of(EXP_W));
  localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MAN_W));

  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] fa;
  logic [MAN_W-1:0] fb;
  logic a_zero;
  logic a_inf;
  logic a_nan;
  logic b_zero;
  logic b_inf;
  logic b_nan;
  logic [W-1:0] inf_q;
  logic [W-1:0] zero_q;

  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_zero = (eb == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  assign sign  = a[W-1] ^ b[W-1];
  assign man_a = {1'b1, fa};
  assign man_b = {1'b1, fb};
  assign exp_q = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

  assign inf_q  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_q = {sign, {(W-1){1'b0}}};

  // Priority order matters: NaN and indeterminate forms first, then x/0
  // (a is known finite nonzero there), then inf/finite (which also covers
  // inf/0), then anything that collapses to zero.
  always_comb begin
    special    = 1'b1;
    spec_q     = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q              = QNAN;
      spec_flags[FLAG_NV] = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_q              = inf_q;
      spec_flags[FLAG_DZ] = 1'b1;
    end else if (a_inf) begin
      spec_q = inf_q;
    end else if (a_zero || b_inf) begin
      spec_q = zero_q;
    end else begin
      special = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider, q = a / b, one quotient bit per
// cycle, round-to-nearest-even, single operation outstanding.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       clock enable; low freezes every register
//   start        request, sampled only with enable high
//   a, b         dividend, divisor (W = 1+EXP_W+MAN_W bits)
//   q, flags     result and {invalid, div_by_zero, overflow, underflow,
//                inexact}; registered, updated only when done rises
//   done         one-cycle pulse (held while enable is low)
//   busy         operation in flight, UNPACK through DONE
//   stall        start seen while busy; such a request is dropped
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] q,
  output logic                 done,
  output logic                 busy,
  output logic                 stall,
  output logic [4:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QB = q_bits_of(MAN_W);
  localparam int CW = $clog2(QB);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE  = (EXP_W+2)'(1);

  logic [2:0]              state;
  logic [W-1:0]            op_a;
  logic [W-1:0]            op_b;
  logic [W-1:0]            res_q;
  logic [4:0]              res_flags;
  logic                    sgn;
  logic signed [EXP_W+1:0] ex;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W:0]          dvs;
  logic [QB-1:0]           quo;
  logic [CW-1:0]           cnt;

  logic                    u_special;
  logic [W-1:0]            u_q;
  logic [4:0]              u_flags;
  logic                    u_sign;
  logic [MAN_W:0]          u_man_a;
  logic [MAN_W:0]          u_man_b;
  logic signed [EXP_W+1:0] u_exp;

  logic                    rem_ge;
  logic [MAN_W+1:0]        rem_sub;

  logic                    norm_msb;
  logic [MAN_W:0]          mant;
  logic                    guard;
  logic                    sticky;
  logic                    rnd_up;
  logic [MAN_W+1:0]        msum;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] e_norm;
  logic signed [EXP_W+1:0] e_fin;
  logic [W-1:0]            rnd_q;
  logic [4:0]              rnd_flags;

  fp_div_unpack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_unpack (
    .a         (op_a),
    .b         (op_b),
    .special   (u_special),
    .spec_q    (u_q),
    .spec_flags(u_flags),
    .sign      (u_sign),
    .man_a     (u_man_a),
    .man_b     (u_man_b),
    .exp_q     (u_exp)
  );

  // Refusal is purely combinational on the registered busy.
  assign stall = busy & start & enable;

  // One restoring-division step. The remainder stays below twice the
  // divisor, so MAN_W+2 bits hold it and the left shift cannot overflow.
  always_comb begin
    rem_ge  = (rem >= {1'b0, dvs});
    rem_sub = rem_ge ? (rem - {1'b0, dvs}) : rem;
  end

  // Normalise, round to nearest even and range-check the finished quotient.
  // When the quotient MSB is set the lowest developed bit lies below the
  // guard position, so it is folded into sticky together with the remainder.
  always_comb begin
    norm_msb = quo[QB-1];
    if (norm_msb) begin
      mant   = quo[QB-1:2];
      guard  = quo[1];
      e_norm = ex;
    end else begin
      mant   = quo[QB-2:1];
      guard  = quo[0];
      e_norm = ex - ONE;
    end
    sticky = (rem != '0) || (norm_msb && quo[0]);
    rnd_up = guard && (sticky || mant[0]);
    msum   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (msum[MAN_W+1]) begin
      frac  = msum[MAN_W:1];
      e_fin = e_norm + ONE;
    end else begin
      frac  = msum[MAN_W-1:0];
      e_fin = e_norm;
    end
    rnd_q              = {sgn, e_fin[EXP_W-1:0], frac};
    rnd_flags          = '0;
    rnd_flags[FLAG_NX] = guard | sticky;
    if (e_fin >= EMAX) begin
      rnd_q              = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags[FLAG_OF] = 1'b1;
      rnd_flags[FLAG_NX] = 1'b1;
    end else if (e_fin[EXP_W+1] || (e_fin == '0)) begin
      rnd_q              = {sgn, {(W-1){1'b0}}};
      rnd_flags[FLAG_UF] = 1'b1;
      rnd_flags[FLAG_NX] = 1'b1;
    end
  end

  // Control FSM and datapath registers. Nothing moves while enable is low,
  // which also keeps done asserted until the next enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      q         <= '0;
      flags     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res_q     <= '0;
      res_flags <= '0;
      sgn       <= 1'b0;
      ex        <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            busy  <= 1'b1;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          sgn <= u_sign;
          if (u_special) begin
            res_q     <= u_q;
            res_flags <= u_flags;
            state     <= ST_DONE;
          end else begin
            rem   <= {1'b0, u_man_a};
            dvs   <= u_man_b;
            ex    <= u_exp;
            quo   <= '0;
            cnt   <= CW'(QB - 1);
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem <= rem_sub << 1;
          quo <= {quo[QB-2:0], rem_ge};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          res_q     <= rnd_q;
          res_flags <= rnd_flags;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          q     <= res_q;
          flags <= res_flags;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: scoreboard bench for fp_div_iter with one binary32 and one
// binary16 instance. Stimulus pushes the hand-computed result and latency;
// per-instance monitors pop and compare on each rising done.
module tb_fp_div_iter;

  typedef struct {
    logic [31:0] q;
    logic [4:0]  flags;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        enable32;
  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [31:0] q32;
  logic        done32;
  logic        busy32;
  logic        stall32;
  logic [4:0]  flags32;

  logic        enable16;
  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [15:0] q16;
  logic        done16;
  logic        busy16;
  logic        stall16;
  logic [4:0]  flags16;

  exp_t sb32[$];
  exp_t sb16[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   doneCount32 = 0;
  int   doneCount16 = 0;
  logic prevDone32 = 1'b0;
  logic prevDone16 = 1'b0;
  int   doneBefore;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .enable(enable32), .start(start32),
    .a(a32), .b(b32), .q(q32), .done(done32), .busy(busy32),
    .stall(stall32), .flags(flags32)
  );

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .enable(enable16), .start(start16),
    .a(a16), .b(b16), .q(q16), .done(done16), .busy(busy16),
    .stall(stall16), .flags(flags16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one request for a full enabled cycle, then record what the
  // scoreboard should see, stamped with the accepting edge.
  task automatic applyStimulus(input bit is16, input string name,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [4:0] expF,
                               input int lat);
    exp_t e;
    @(negedge clk);
    if (is16) begin
      a16 = a[15:0]; b16 = b[15:0]; enable16 = 1'b1; start16 = 1'b1;
    end else begin
      a32 = a; b32 = b; enable32 = 1'b1; start32 = 1'b1;
    end
    @(posedge clk);
    #1;
    start16 = 1'b0;
    start32 = 1'b0;
    e.q = expQ; e.flags = expF; e.lat = lat; e.issue = cyc; e.name = name;
    if (is16) sb16.push_back(e);
    else sb32.push_back(e);
  endtask

  task automatic waitDrain(input bit is16, input int maxCycles);
    int n;
    n = 0;
    while ((is16 ? sb16.size() : sb32.size()) != 0 && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(is16 ? "drain16" : "drain32",
                32'(is16 ? sb16.size() : sb32.size()), 32'd0);
    if (is16) sb16.delete();
    else sb32.delete();
  endtask

  // Monitor for the binary32 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done32 && !prevDone32) begin
      doneCount32 <= doneCount32 + 1;
      if (sb32.size() == 0) begin
        checkOutput("unexpected_done32", 32'd1, 32'd0);
      end else begin
        e = sb32.pop_front();
        checkOutput({e.name, "_q"}, q32, e.q);
        checkOutput({e.name, "_flags"}, {27'd0, flags32}, {27'd0, e.flags});
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
    prevDone32 <= done32;
  end

  // Monitor for the binary16 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done16 && !prevDone16) begin
      doneCount16 <= doneCount16 + 1;
      if (sb16.size() == 0) begin
        checkOutput("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = sb16.pop_front();
        checkOutput({e.name, "_q"}, {16'd0, q16}, e.q);
        checkOutput({e.name, "_flags"}, {27'd0, flags16}, {27'd0, e.flags});
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
    prevDone16 <= done16;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enable32 = 1'b1; start32 = 1'b0; a32 = '0; b32 = '0;
    enable16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_q32", q32, 32'd0);
    checkOutput("rst_flags32", {27'd0, flags32}, 32'd0);
    checkOutput("rst_done32", {31'd0, done32}, 32'd0);
    checkOutput("rst_busy32", {31'd0, busy32}, 32'd0);
    checkOutput("rst_q16", {16'd0, q16}, 32'd0);
    checkOutput("rst_busy16", {31'd0, busy16}, 32'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(0, "b32_div1", 32'hC396D200, 32'hC0100000, 32'h43061000, 5'b00000, 29);
    waitDrain(0, 60);
    applyStimulus(0, "b32_div2", 32'h40AE0000, 32'hBEC00000, 32'hC1680000, 5'b00000, 29);
    waitDrain(0, 60);
    applyStimulus(0, "b32_divzero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
    waitDrain(0, 20);
    applyStimulus(0, "b32_zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2);
    waitDrain(0, 20);
    applyStimulus(0, "b32_inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2);
    waitDrain(0, 20);
    applyStimulus(0, "b32_overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 29);
    waitDrain(0, 60);
    applyStimulus(0, "b32_underflow", 32'h00800000, 32'h4F000000, 32'h00000000, 5'b00011, 29);
    waitDrain(0, 60);

    applyStimulus(1, "b16_div1", 32'h00003E00, 32'h00003800, 32'h00004200, 5'b00000, 16);
    waitDrain(1, 40);
    applyStimulus(1, "b16_third", 32'h00003C00, 32'h00004200, 32'h00003555, 5'b00001, 16);
    waitDrain(1, 40);

    // start held high for the whole operation
    $display("[TB] handshake: start held high");
    doneBefore = doneCount32;
    @(negedge clk);
    a32 = 32'h40AE0000; b32 = 32'hBEC00000; start32 = 1'b1; enable32 = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.q = 32'hC1680000; e.flags = 5'b0; e.lat = 29; e.issue = cyc; e.name = "hs_held";
      sb32.push_back(e);
    end
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      checkOutput("hs_busy", {31'd0, busy32}, 32'd1);
      checkOutput("hs_stall", {31'd0, stall32}, 32'd1);
    end
    @(negedge clk);
    checkOutput("hs_stall_after_done", {31'd0, stall32}, 32'd0);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("hs_one_done", 32'(doneCount32 - doneBefore), 32'd1);
    waitDrain(0, 5);

    // enable toggled every cycle doubles the latency
    $display("[TB] enable toggling");
    applyStimulus(0, "b32_toggle", 32'hC396D200, 32'hC0100000, 32'h43061000, 5'b00000, 58);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      enable32 = ~enable32;
    end
    enable32 = 1'b1;
    waitDrain(0, 10);

    // reset in the middle of the divide loop
    $display("[TB] reset mid-operation");
    applyStimulus(0, "b32_aborted", 32'h40AE0000, 32'hBEC00000, 32'hC1680000, 5'b00000, 29);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    start32 = 1'b1;
    #1;
    checkOutput("abort_q", q32, 32'd0);
    checkOutput("abort_flags", {27'd0, flags32}, 32'd0);
    checkOutput("abort_done", {31'd0, done32}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy32}, 32'd0);
    checkOutput("abort_stall", {31'd0, stall32}, 32'd0);
    sb32.delete();
    @(negedge clk);
    start32 = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abort_idle_busy", {31'd0, busy32}, 32'd0);
    applyStimulus(0, "b32_after_reset", 32'h40AE0000, 32'hBEC00000, 32'hC1680000, 5'b00000, 29);
    waitDrain(0, 60);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised iterative IEEE-754 divider with a start/busy/stall/enable handshake, computing q = a / b one quotient bit per cycle. It generalises the fixed binary32 divider interface to any exponent/mantissa width, e.g. binary16 or binary32. It adds round-to-nearest-even and exception flags, and sits behind the FPU issue logic as a single-outstanding-operation unit.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  clock enable; low freezes all state and outputs
- start  in  1  request; sampled only when enable=1
- a  in  W  dividend
- b  in  W  divisor
- q  out  W  quotient; held until next done
- done  out  1  one-cycle pulse, q/flags valid
- busy  out  1  operation in flight
- stall  out  1  start asserted while busy (request refused)
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

## Operation
- Reset: q=0, flags=0, done=0, busy=0, stall=0, state IDLE, all datapath registers 0. Reset mid-operation aborts with no done.
- FSM states: IDLE, UNPACK, DIV, ROUND, DONE.
- IDLE: start&enable -> latch a,b into operand regs, busy=1, go UNPACK.
- UNPACK: classify each operand as zero, inf, NaN, or normal. Exponent 0 is treated as zero (subnormals flush to zero, no underflow flag on inputs). Sign = sa^sb.
  - Special results go straight to DONE: NaN in, 0/0 or inf/inf -> canonical qNaN (exp all-ones, fraction MSB 1, sign 0), invalid=1.
  - x/0 with x finite nonzero -> signed inf, div_by_zero=1.
  - inf/finite -> signed inf; finite/inf or 0/finite -> signed zero.
  - Otherwise: load remainder = 1.fa, divisor = 1.fb, exponent e = ea - eb + BIAS in EXP_W+2 signed bits, counter = Q_BITS-1, go DIV.
- DIV: restoring division, one bit per cycle. Each step: if rem >= div, then rem -= div and the quotient bit is 1; then rem <<= 1. Q_BITS = MAN_W+3 (hidden, fraction, normalise, guard). At counter 0 go ROUND.
- ROUND: sticky = (rem != 0).
  - Quotient MSB 0 -> shift left 1, e -= 1.
  - Round to nearest even on guard/sticky; mantissa carry-out -> shift right, e += 1.
  - inexact = guard|sticky.
  - e >= all-ones -> signed inf, overflow=1, inexact=1.
  - e <= 0 -> signed zero, underflow=1, inexact=1.
- DONE: drive q/flags, done=1 for one cycle, busy=0 next cycle, go IDLE. start in DONE is refused (stall=1).
- stall = busy & start & enable (combinational from registered busy). A refused request is dropped, not queued.
- enable=0 in any state: no transition, counter and registers hold, done held at its current value.

## Timing
- Accepted start at edge N: busy=1 from N+1.
- Normal path: done at cycle N+Q_BITS+3 (binary32: 29 cycles; binary16: 16 cycles).
- Special path: done at N+2.
- busy covers UNPACK through DONE inclusive.
- Earliest next accept is the cycle after done.
- Each enable=0 cycle delays all of the above by one.
- q, flags registered; they change only on the cycle done rises.

## Structure
- Package fp_div_pkg: state enum, flag bit indices (FLAG_NV=4 … FLAG_NX=0), Q_BITS and BIAS derivation functions, canonical NaN constructor.
- Sub-module fp_div_unpack: combinational classify/sign/exponent-difference for one operand pair; instantiated once, used in UNPACK.
- FSM, divide loop and rounding in fp_div_iter.

## Test plan
- binary32: a=C396D200, b=C0100000 -> q=43061000 at start+29, flags=0. Then a=40AE0000, b=BEC00000 -> C1680000.
- binary16 (EXP_W=5, MAN_W=10): a=3E00, b=3800 -> q=4200 at start+16. Then 3C00/4200 -> 3555, inexact=1.
- Specials (binary32):
  - 3F800000/00000000 -> 7F800000, div_by_zero, done at +2.
  - 00000000/00000000 -> 7FC00000, invalid.
  - 7F800000/7F800000 -> 7FC00000, invalid.
- Range (binary32):
  - 7F000000/3E800000 -> 7F800000, overflow|inexact.
  - 00800000/4F000000 -> 00000000, underflow|inexact.
- Handshake: start held high through the op -> stall=1 every busy cycle, exactly one done. enable toggled 50% -> done at 2x latency, same q.
- Reset asserted at DIV cycle 10 -> all outputs 0 immediately, no done. New start after release completes normally.
